// File: rtl/downsample_scheduler_if.sv
// Feature-map buffer port bundle: ifmap read request/response and ofmap write channels.
// The scheduler connects through master and the SRAM wrappers connect through slave.
interface downsample_scheduler_if #(
   parameter int RD_ADDR_W = 10,
   parameter int WR_ADDR_W = 9,
   parameter int DATA_W    = 8
);
   logic                 rd_req_valid;
   logic                 rd_req_ready;
   logic [RD_ADDR_W-1:0] rd_addr;
   logic                 rd_rsp_valid;
   logic [DATA_W-1:0]    rd_rsp_data;
   logic                 wr_valid;
   logic                 wr_ready;
   logic [WR_ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]    wr_data;

   modport master (
      output rd_req_valid, rd_addr, wr_valid, wr_addr, wr_data,
      input  rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_ready
   );

   modport slave (
      input  rd_req_valid, rd_addr, wr_valid, wr_addr, wr_data,
      output rd_req_ready, rd_rsp_valid, rd_rsp_data, wr_ready
   );
endinterface

// File: rtl/downsample_scheduler.sv
// Fractional-stride nearest-neighbour downsample sequencer: one ifmap read, one ofmap write per pixel.
// Build option DOWNSAMPLE_ROUND_NEAREST_EN selects round-half-up source indexing instead of floor.
//
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | read request presented, waiting for rd_req_ready
//   WAIT  | read outstanding, waiting for rd_rsp_valid
//   WRITE | write presented, waiting for wr_ready
//   DONE  | one-cycle completion pulse
module downsample_scheduler #(
   parameter int HIN       = 27,
   parameter int HOUT      = 19,
   parameter int DATA_W    = 8,
   parameter int FRAC_W    = 8,
   parameter int STRIDE_Q  = 370,
   parameter int RD_ADDR_W = $clog2(HIN*HIN),
   parameter int WR_ADDR_W = $clog2(HOUT*HOUT)
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   downsample_scheduler_if.master fm
);
   localparam int ACC_W = $clog2(HOUT*STRIDE_Q) + 1;
   localparam int CNT_W = $clog2(HOUT);
   localparam int SRC_W = $clog2(HIN);
   localparam int Q_W   = ACC_W - FRAC_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HOUT-1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]     out_row, out_col, row_nxt, col_nxt;
   logic [ACC_W-1:0]     row_acc, col_acc, row_acc_nxt, col_acc_nxt;
   logic                 last;
   logic [RD_ADDR_W-1:0] rd_addr_nxt;
   logic [WR_ADDR_W-1:0] wr_addr_nxt;

   function automatic logic [SRC_W-1:0] src_of(input logic [ACC_W-1:0] acc);
      logic [ACC_W:0] sum;
      logic [Q_W-1:0] q;
`ifdef DOWNSAMPLE_ROUND_NEAREST_EN
      sum = {1'b0, acc} + (ACC_W+1)'(2**(FRAC_W-1));
`else
      sum = {1'b0, acc};
`endif
      q = Q_W'(sum >> FRAC_W);
      if (q > Q_W'(HIN-1))
         return SRC_W'(HIN-1);
      return q[SRC_W-1:0];
   endfunction

   // Coordinates and addresses of the pixel after the current one.
   always_comb begin
      last = (out_row == LAST) && (out_col == LAST);
      if (out_col == LAST) begin
         col_nxt     = '0;
         col_acc_nxt = '0;
         row_nxt     = out_row + 1'b1;
         row_acc_nxt = row_acc + ACC_W'(STRIDE_Q);
      end else begin
         col_nxt     = out_col + 1'b1;
         col_acc_nxt = col_acc + ACC_W'(STRIDE_Q);
         row_nxt     = out_row;
         row_acc_nxt = row_acc;
      end
      rd_addr_nxt = RD_ADDR_W'(src_of(row_acc_nxt)) * RD_ADDR_W'(HIN)
                  + RD_ADDR_W'(src_of(col_acc_nxt));
      wr_addr_nxt = WR_ADDR_W'(row_nxt) * WR_ADDR_W'(HOUT) + WR_ADDR_W'(col_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)           state_nxt = REQ;
         REQ:     if (fm.rd_req_ready) state_nxt = WAIT;
         WAIT:    if (fm.rd_rsp_valid) state_nxt = WRITE;
         WRITE:   if (fm.wr_ready)     state_nxt = last ? DONE : REQ;
         DONE:                         state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy            = (state == REQ) || (state == WAIT) || (state == WRITE);
      done            = (state == DONE);
      fm.rd_req_valid = (state == REQ);
      fm.wr_valid     = (state == WRITE);
   end

   // Addresses are loaded on entry to REQ so they are stable before either valid rises.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_row    <= '0;
         out_col    <= '0;
         row_acc    <= '0;
         col_acc    <= '0;
         fm.rd_addr <= '0;
         fm.wr_addr <= '0;
         fm.wr_data <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               out_row    <= '0;
               out_col    <= '0;
               row_acc    <= '0;
               col_acc    <= '0;
               fm.rd_addr <= '0;
               fm.wr_addr <= '0;
            end
            WAIT: if (fm.rd_rsp_valid)
               fm.wr_data <= DATA_W'(fm.rd_rsp_data);
            WRITE: if (fm.wr_ready && !last) begin
               out_row    <= row_nxt;
               out_col    <= col_nxt;
               row_acc    <= row_acc_nxt;
               col_acc    <= col_acc_nxt;
               fm.rd_addr <= rd_addr_nxt;
               fm.wr_addr <= wr_addr_nxt;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_downsample_scheduler.sv
// Bench for downsample_scheduler: buffer models with configurable stalls and a coordinate-level reference.
// Honours DOWNSAMPLE_ROUND_NEAREST_EN the same way the design does.
module tb_downsample_scheduler;
   localparam int HIN = 27, HOUT = 19, DATA_W = 8, FRAC_W = 8, STRIDE_Q = 370;
   localparam int RD_ADDR_W = 10, WR_ADDR_W = 9, NPIX = HOUT*HOUT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done;

   always #5 clk = ~clk;

   downsample_scheduler_if #(.RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W), .DATA_W(DATA_W)) fm ();

   downsample_scheduler #(
      .HIN(HIN), .HOUT(HOUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .STRIDE_Q(STRIDE_Q),
      .RD_ADDR_W(RD_ADDR_W), .WR_ADDR_W(WR_ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .fm(fm)
   );

   int checks = 0, failures = 0;
   logic [7:0] ifmap [HIN*HIN];
   int rd_q[$];
   int wr_a_q[$];
   int wr_d_q[$];
   int done_cnt = 0, busy_cyc = 0, stab_err = 0, outst_err = 0;
   int mode = 0;        // 0 zero-wait, 1 random stalls, 2 fixed long stalls
   int stray_req = 0;

   // Nearest source index for output coordinate k, straight from the stride definition.
   function automatic int src_of(int k);
      int v;
`ifdef DOWNSAMPLE_ROUND_NEAREST_EN
      v = (k*STRIDE_Q + 2**(FRAC_W-1)) / 2**FRAC_W;
`else
      v = (k*STRIDE_Q) / 2**FRAC_W;
`endif
      return (v > HIN-1) ? HIN-1 : v;
   endfunction

   function automatic int exp_rd(int p);
      return src_of(p / HOUT) * HIN + src_of(p % HOUT);
   endfunction

   function automatic int pick(int lim);
      if (mode == 0) return 0;
      if (mode == 1) return $urandom_range(0, lim);
      return lim;
   endfunction

   function automatic int rd_at(int i);
      return (i < rd_q.size()) ? rd_q[i] : -1;
   endfunction

   function automatic int wr_at(int i);
      return (i < wr_a_q.size()) ? wr_a_q[i] : -1;
   endfunction

   // Buffer models and bus monitor.
   initial begin
      int rd_cnt = 0, wr_cnt = 0, rd_tgt = 0, wr_tgt = 0;
      int rsp_left = 0, rsp_addr = 0, stray_ack = 0;
      int p_rd_addr = 0, p_wr_addr = 0, p_wr_data = 0;
      bit rsp_pend = 0, p_rd_stall = 0, p_wr_stall = 0, outst = 0;
      fm.rd_req_ready = 1'b0;
      fm.rd_rsp_valid = 1'b0;
      fm.rd_rsp_data  = '0;
      fm.wr_ready     = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (fm.rd_req_valid && rd_cnt < rd_tgt) begin
            fm.rd_req_ready = 1'b0;
            rd_cnt++;
         end else fm.rd_req_ready = fm.rd_req_valid;
         if (fm.wr_valid && wr_cnt < wr_tgt) begin
            fm.wr_ready = 1'b0;
            wr_cnt++;
         end else fm.wr_ready = fm.wr_valid;
         fm.rd_rsp_valid = 1'b0;
         if (stray_ack != stray_req) begin
            stray_ack = stray_req;
            fm.rd_rsp_valid = 1'b1;
            fm.rd_rsp_data  = 8'hA5;
         end else if (rsp_pend) begin
            if (rsp_left == 0) begin
               fm.rd_rsp_valid = 1'b1;
               fm.rd_rsp_data  = ifmap[rsp_addr];
               rsp_pend = 0;
            end else rsp_left--;
         end
         @(negedge clk);
         if (busy) busy_cyc++;
         if (done) done_cnt++;
         if (!rst) begin
            if (p_rd_stall && !(fm.rd_req_valid && int'(fm.rd_addr) == p_rd_addr)) stab_err++;
            if (p_wr_stall && !(fm.wr_valid && int'(fm.wr_addr) == p_wr_addr &&
                                int'(fm.wr_data) == p_wr_data)) stab_err++;
         end
         p_rd_stall = !rst && fm.rd_req_valid && !fm.rd_req_ready;
         p_wr_stall = !rst && fm.wr_valid && !fm.wr_ready;
         p_rd_addr  = int'(fm.rd_addr);
         p_wr_addr  = int'(fm.wr_addr);
         p_wr_data  = int'(fm.wr_data);
         if (rst) begin
            outst = 0; rd_cnt = 0; wr_cnt = 0;
         end else begin
            if (fm.rd_req_valid && fm.rd_req_ready) begin
               if (outst) outst_err++;
               outst = 1;
               rd_q.push_back(int'(fm.rd_addr));
               rsp_pend = 1;
               rsp_addr = int'(fm.rd_addr);
               rsp_left = pick(3);
               rd_cnt = 0;
               rd_tgt = pick(5);
            end
            if (fm.wr_valid && fm.wr_ready) begin
               outst = 0;
               wr_a_q.push_back(int'(fm.wr_addr));
               wr_d_q.push_back(int'(fm.wr_data));
               wr_cnt = 0;
               wr_tgt = pick(4);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int d0, input int lim);
      int n = 0;
      while (done_cnt == d0 && !done && n < lim) begin
         tick();
         n++;
      end
   endtask

   task automatic check_frame(input string tag, input int rb, input int wb);
      int mism = 0;
      chk({tag, " rd_count"}, rd_q.size() - rb, NPIX);
      chk({tag, " wr_count"}, wr_a_q.size() - wb, NPIX);
      for (int p = 0; p < NPIX; p++) begin
         if (rd_at(rb+p) != exp_rd(p)) mism++;
         if (wr_at(wb+p) != p) mism++;
         else if (wr_d_q[wb+p] != int'(ifmap[exp_rd(p)])) mism++;
      end
      chk({tag, " seq_mismatches"}, mism, 0);
      chk({tag, " stall_stability_errs"}, stab_err, 0);
      chk({tag, " outstanding_errs"}, outst_err, 0);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int rb_a, wb_a, rb, wb, d0, b0, mism, n;
      int first_cols[6];
`ifdef DOWNSAMPLE_ROUND_NEAREST_EN
      first_cols = '{0, 1, 3, 4, 6, 7};
`else
      first_cols = '{0, 1, 2, 4, 5, 7};
`endif
      foreach (ifmap[i]) ifmap[i] = 8'($urandom);

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset rd_req_valid", fm.rd_req_valid, 0);
      chk("reset wr_valid", fm.wr_valid, 0);
      chk("reset rd_addr", fm.rd_addr, 0);
      chk("reset wr_addr", fm.wr_addr, 0);
      chk("reset wr_data", fm.wr_data, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Frame A: zero-wait buffers
      mode = 0;
      rb_a = rd_q.size(); wb_a = wr_a_q.size(); d0 = done_cnt; b0 = busy_cyc;
      start_pulse();
      chk("A busy after start", busy, 1);
      chk("A rd_req_valid first", fm.rd_req_valid, 1);
      chk("A rd_addr first", fm.rd_addr, 0);
      wait_done(d0, 20000);
      chk("A done pulse", done, 1);
      chk("A busy in done", busy, 0);
      tick();
      chk("A done single", done, 0);
      chk("A done count", done_cnt - d0, 1);
      chk("A busy cycles", busy_cyc - b0, NPIX*3);
      for (int k = 0; k < 6; k++) chk("A first row src col", rd_at(rb_a+k), first_cols[k]);
      chk("A last col of row 0", rd_at(rb_a+HOUT-1), HIN-1);
      chk("A row 1 start", rd_at(rb_a+HOUT), HIN);
      chk("A final rd_addr", rd_at(rb_a+NPIX-1), HIN*HIN-1);
      chk("A final wr_addr", wr_at(wb_a+NPIX-1), NPIX-1);
      check_frame("A", rb_a, wb_a);

      // Frame B: start in the cycle after done, random stalls
      mode = 1;
      rb = rd_q.size(); wb = wr_a_q.size(); d0 = done_cnt;
      start_pulse();
      wait_done(d0, 40000);
      tick();
      chk("B done count", done_cnt - d0, 1);
      mism = 0;
      for (int p = 0; p < NPIX; p++) if (rd_at(rb+p) != rd_at(rb_a+p)) mism++;
      chk("B addr seq vs frame A", mism, 0);
      check_frame("B", rb, wb);

      // Frame C: long fixed stalls, ifmap (i+j)%256, start pulsed while busy
      mode = 2;
      foreach (ifmap[a]) ifmap[a] = 8'((a / HIN + a % HIN) % 256);
      repeat (2) tick();
      rb = rd_q.size(); wb = wr_a_q.size(); d0 = done_cnt;
      start_pulse();
      repeat (7) tick();
      start_pulse();
      wait_done(d0, 40000);
      repeat (12) tick();
      chk("C done count", done_cnt - d0, 1);
      chk("C idle after frame", busy, 0);
      check_frame("C", rb, wb);

      // Frame D: reset during WAIT at pixel 100, start coincident with reset
      rb = rd_q.size(); wb = wr_a_q.size(); d0 = done_cnt;
      start_pulse();
      n = 0;
      while (!(wr_a_q.size() - wb == 100 && busy && !fm.rd_req_valid && !fm.wr_valid) && n < 20000) begin
         tick();
         n++;
      end
      chk("D reached WAIT at pixel 100", wr_a_q.size() - wb, 100);
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      chk("D rst busy", busy, 0);
      chk("D rst rd_req_valid", fm.rd_req_valid, 0);
      chk("D rst wr_valid", fm.wr_valid, 0);
      chk("D rst rd_addr", fm.rd_addr, 0);
      chk("D rst wr_addr", fm.wr_addr, 0);
      chk("D rst wr_data", fm.wr_data, 0);
      stray_req++;
      repeat (8) tick();
      chk("D no write after rst", wr_a_q.size() - wb, 100);
      chk("D start with rst ignored", busy, 0);
      chk("D no done after rst", done_cnt - d0, 0);

      // Frame E: fresh start after reset
      mode = 0;
      rb = rd_q.size(); wb = wr_a_q.size(); d0 = done_cnt;
      start_pulse();
      wait_done(d0, 20000);
      tick();
      chk("E first wr_addr", wr_at(wb), 0);
      chk("E done count", done_cnt - d0, 1);
      check_frame("E", rb, wb);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
